// File: rtl/ipml_mc_fifo_pkg.sv
// Shared helpers and types for the multi-channel FIFO: width functions,
// per-channel flag bundle with its reset value, and the level update opcode.
package ipml_mc_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : clog2(num_ch);
    endfunction

    function automatic int level_width(input int depth_width);
        return depth_width + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } ch_flags_t;

    localparam ch_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};

    typedef enum logic [1:0] {
        LVL_HOLD,
        LVL_INC,
        LVL_DEC
    } lvl_op_e;

endpackage

// File: rtl/ipml_mc_fifo_if.sv
// Request/response bundle of the multi-channel FIFO; the producer/consumer
// side uses the master modport, the FIFO itself the slave modport.
interface ipml_mc_fifo_if
    import ipml_mc_fifo_pkg::*;
#(
    parameter int C_CH          = 4,
    parameter int C_CH_WIDTH    = ch_width(C_CH),
    parameter int C_DEPTH_WIDTH = 4,
    parameter int C_DATA_WIDTH  = 32
);
    logic                                  wr_en;
    logic [C_CH_WIDTH-1:0]                 wr_ch;
    logic [C_DATA_WIDTH-1:0]               wr_data;
    logic                                  rd_en;
    logic [C_CH_WIDTH-1:0]                 rd_ch;
    logic [C_DATA_WIDTH-1:0]               rd_data;
    logic                                  rd_valid;
    logic [C_CH-1:0]                       clr_ch;
    logic [C_CH-1:0]                       wr_full;
    logic [C_CH-1:0]                       rd_empty;
    logic [C_CH-1:0]                       almost_full;
    logic [C_CH-1:0]                       almost_empty;
    logic [C_CH*(C_DEPTH_WIDTH+1)-1:0]     water_level;
    logic [C_CH-1:0]                       overflow;
    logic [C_CH-1:0]                       underflow;

    modport master (
        output wr_en, wr_ch, wr_data, rd_en, rd_ch, clr_ch,
        input  rd_data, rd_valid, wr_full, rd_empty, almost_full, almost_empty,
               water_level, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, rd_en, rd_ch, clr_ch,
        output rd_data, rd_valid, wr_full, rd_empty, almost_full, almost_empty,
               water_level, overflow, underflow
    );
endinterface

// File: rtl/ipml_mc_fifo_ch_ctrl_v1_0.sv
// Bookkeeping for one logical channel: pointers, fill level, flags and
// sticky overflow/underflow. Accept/reject decisions are made by the top.
module ipml_mc_fifo_ch_ctrl_v1_0
    import ipml_mc_fifo_pkg::*;
#(
    parameter int C_DEPTH_WIDTH      = 4,
    parameter int C_ALMOST_FULL_NUM  = 14,
    parameter int C_ALMOST_EMPTY_NUM = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_acc,
    input  logic                     rd_acc,
    input  logic                     wr_ovf,
    input  logic                     rd_unf,
    input  logic                     clr,
    output logic [C_DEPTH_WIDTH-1:0] wr_ptr,
    output logic [C_DEPTH_WIDTH-1:0] rd_ptr,
    output logic [C_DEPTH_WIDTH:0]   level,
    output ch_flags_t                flags,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int              LW    = level_width(C_DEPTH_WIDTH);
    localparam logic [LW-1:0]   DEPTH = LW'(2 ** C_DEPTH_WIDTH);

    lvl_op_e lvl_op;

    always_comb begin
        unique case ({wr_acc, rd_acc})
            2'b10:   lvl_op = LVL_INC;
            2'b01:   lvl_op = LVL_DEC;
            default: lvl_op = LVL_HOLD;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            unique case (lvl_op)
                LVL_INC: level <= level + 1'b1;
                LVL_DEC: level <= level - 1'b1;
                default: level <= level;
            endcase
            if (wr_ovf) overflow  <= 1'b1;
            if (rd_unf) underflow <= 1'b1;
        end
    end

    always_comb begin
        flags.full         = (level == DEPTH);
        flags.empty        = (level == '0);
        flags.almost_full  = (level >= LW'(C_ALMOST_FULL_NUM));
        flags.almost_empty = (level <= LW'(C_ALMOST_EMPTY_NUM));
    end

endmodule

// File: rtl/ipml_mc_fifo_v1_0.sv
// Multi-channel synchronous FIFO sharing one simple-dual-port RAM addressed
// as {channel, pointer}. Define IPML_MC_FIFO_OUTREG_EN for a 2-cycle read path.
module ipml_mc_fifo_v1_0
    import ipml_mc_fifo_pkg::*;
#(
    parameter int C_CH               = 4,
    parameter int C_DEPTH_WIDTH      = 4,
    parameter int C_DATA_WIDTH       = 32,
    parameter int C_ALMOST_FULL_NUM  = 14,
    parameter int C_ALMOST_EMPTY_NUM = 2
) (
    input logic           clk,
    input logic           rst,
    ipml_mc_fifo_if.slave bus
);
    localparam int C_CH_WIDTH = ch_width(C_CH);
    localparam int LW         = level_width(C_DEPTH_WIDTH);
    localparam int DEPTH      = 2 ** C_DEPTH_WIDTH;
    localparam int ADDR_W     = C_CH_WIDTH + C_DEPTH_WIDTH;

    logic [C_CH-1:0]          wr_sel, rd_sel, wr_acc, rd_acc, wr_ovf, rd_unf;
    logic [C_DEPTH_WIDTH-1:0] wr_ptr [C_CH];
    logic [C_DEPTH_WIDTH-1:0] rd_ptr [C_CH];
    logic [LW-1:0]            level  [C_CH];
    ch_flags_t                flags  [C_CH];

    logic [C_DEPTH_WIDTH-1:0] wr_ptr_sel, rd_ptr_sel;
    logic [ADDR_W-1:0]        wr_addr, rd_addr;
    logic [C_DATA_WIDTH-1:0]  mem [C_CH*DEPTH];
    logic [C_DATA_WIDTH-1:0]  rd_data_q;
    logic                     rd_valid_q;

    // Out-of-range channel numbers match no slot, so they touch nothing.
    for (genvar g = 0; g < C_CH; g++) begin : g_ch
        assign wr_sel[g] = bus.wr_en && (bus.wr_ch == C_CH_WIDTH'(g)) && !bus.clr_ch[g];
        assign rd_sel[g] = bus.rd_en && (bus.rd_ch == C_CH_WIDTH'(g)) && !bus.clr_ch[g];
        assign wr_acc[g] = wr_sel[g] && !flags[g].full;
        assign wr_ovf[g] = wr_sel[g] &&  flags[g].full;
        assign rd_acc[g] = rd_sel[g] && !flags[g].empty;
        assign rd_unf[g] = rd_sel[g] &&  flags[g].empty;

        ipml_mc_fifo_ch_ctrl_v1_0 #(
            .C_DEPTH_WIDTH     (C_DEPTH_WIDTH),
            .C_ALMOST_FULL_NUM (C_ALMOST_FULL_NUM),
            .C_ALMOST_EMPTY_NUM(C_ALMOST_EMPTY_NUM)
        ) u_ch_ctrl (
            .clk      (clk),
            .rst      (rst),
            .wr_acc   (wr_acc[g]),
            .rd_acc   (rd_acc[g]),
            .wr_ovf   (wr_ovf[g]),
            .rd_unf   (rd_unf[g]),
            .clr      (bus.clr_ch[g]),
            .wr_ptr   (wr_ptr[g]),
            .rd_ptr   (rd_ptr[g]),
            .level    (level[g]),
            .flags    (flags[g]),
            .overflow (bus.overflow[g]),
            .underflow(bus.underflow[g])
        );

        assign bus.wr_full[g]              = flags[g].full;
        assign bus.rd_empty[g]             = flags[g].empty;
        assign bus.almost_full[g]          = flags[g].almost_full;
        assign bus.almost_empty[g]         = flags[g].almost_empty;
        assign bus.water_level[g*LW +: LW] = level[g];
    end

    // NOTE: defaults before the loop keep this purely combinational (no latch).
    always_comb begin
        wr_ptr_sel = '0;
        rd_ptr_sel = '0;
        for (int i = 0; i < C_CH; i++) begin
            if (wr_sel[i]) wr_ptr_sel = wr_ptr[i];
            if (rd_sel[i]) rd_ptr_sel = rd_ptr[i];
        end
    end

    assign wr_addr = {bus.wr_ch, wr_ptr_sel};
    assign rd_addr = {bus.rd_ch, rd_ptr_sel};

    // NOTE: the array has no reset so it maps onto block RAM; stale words
    // are unreachable because the pointers and levels are reset instead.
    always_ff @(posedge clk) begin
        if (!rst && |wr_acc) mem[wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= |rd_acc;
            if (|rd_acc) rd_data_q <= mem[rd_addr];
        end
    end

`ifdef IPML_MC_FIFO_OUTREG_EN
    logic [C_DATA_WIDTH-1:0] rd_data_q2;
    logic                    rd_valid_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q2  <= '0;
            rd_valid_q2 <= 1'b0;
        end else begin
            rd_valid_q2 <= rd_valid_q;
            if (rd_valid_q) rd_data_q2 <= rd_data_q;
        end
    end

    assign bus.rd_data  = rd_data_q2;
    assign bus.rd_valid = rd_valid_q2;
`else
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

endmodule
